// File: rtl/hnf_rxreq_lcrd_ctrl.sv
// HN-F RXREQ L-credit / link-state controller: link handshake, credit grants bounded by POSQ space,
// flit qualification into POSQ writes. Optional macro HNF_RXREQ_LCRD_THROTTLE_EN adds cfg_lcrd_limit.
module hnf_rxreq_lcrd_ctrl #(
    parameter int POSQ_DEPTH = 8,
    parameter int MAX_LCRD   = 15,
    parameter int CNT_W      = $clog2(POSQ_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             link_active_req,
    output logic             link_active_ack,
    input  logic             rxreqflitv,
    input  logic             rxreqflit_is_lcrd_return,
    output logic             RXREQLCRDV,
    output logic             posq_winc,
    input  logic             posq_pop,
`ifdef HNF_RXREQ_LCRD_THROTTLE_EN
    input  logic [3:0]       cfg_lcrd_limit,
`endif
    output logic [3:0]       lcrd_outstanding,
    output logic [CNT_W-1:0] posq_count,
    output logic             proto_err
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_ACT   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DEACT = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             ack_q;
    logic             lcrdv_q, lcrdv_d;
    logic [3:0]       out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [4:0] limit;
    logic [4:0] out_pend;
    logic [7:0] used;
    logic       flit_ok, flit_bad, pop_ok, pop_bad;

`ifdef HNF_RXREQ_LCRD_THROTTLE_EN
    assign limit = ({1'b0, cfg_lcrd_limit} < 5'(MAX_LCRD)) ? {1'b0, cfg_lcrd_limit} : 5'(MAX_LCRD);
`else
    assign limit = 5'(MAX_LCRD);
`endif

    // A grant in flight counts as outstanding so the POSQ can never be oversubscribed.
    assign out_pend = {1'b0, out_q} + 5'(lcrdv_q);
    assign used     = 8'(cnt_q) + 8'(out_q) + 8'(lcrdv_q);

    assign flit_ok   = rxreqflitv && (state_q != ST_STOP) && (out_q != 4'd0);
    assign flit_bad  = rxreqflitv && !flit_ok;
    assign pop_ok    = posq_pop && (cnt_q != '0);
    assign pop_bad   = posq_pop && (cnt_q == '0);
    assign posq_winc = flit_ok && !rxreqflit_is_lcrd_return;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  if (link_active_req) state_d = ST_ACT;
            ST_ACT:   state_d = ST_RUN;
            ST_RUN:   if (!link_active_req) state_d = ST_DEACT;
            ST_DEACT: if (out_q == 4'd0 && !lcrdv_q && !rxreqflitv) state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        lcrdv_d = (state_q == ST_RUN) && link_active_req && (out_pend < limit)
                  && (used < 8'(POSQ_DEPTH));
        out_d   = out_q + 4'(lcrdv_q) - 4'(flit_ok);
        cnt_d   = cnt_q + CNT_W'(posq_winc) - CNT_W'(pop_ok);
        err_d   = err_q || flit_bad || pop_bad;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_STOP;
            ack_q   <= 1'b0;
            lcrdv_q <= 1'b0;
            out_q   <= 4'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= (state_d != ST_STOP);
            lcrdv_q <= lcrdv_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign link_active_ack  = ack_q;
    assign RXREQLCRDV       = lcrdv_q;
    assign lcrd_outstanding = out_q;
    assign posq_count       = cnt_q;
    assign proto_err        = err_q;

endmodule
